// File: rtl/demux14_key.sv
// rtl/demux14_key.sv - key-stepped 1-to-4 demultiplexer onto an active-low LED bank
module demux14_key #(
  parameter int DB_CNT   = 240000,
  parameter int SEL_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       key1,
  input  logic       key2,
  output logic [3:0] led,
  output logic [1:0] sel
);

  localparam int             CW      = $clog2(DB_CNT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CNT - 1);
  localparam logic [1:0]     SEL_RST = 2'(SEL_INIT);

  logic          din_s1_q, din_s_q;
  logic [1:0]    key_s1_q, key_s_q;
  logic [1:0]    stable_q, stable_d, stable_d1_q;
  logic [1:0]    press_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    led_q, led_d;

  // Bit 0 is key1 (forward), bit 1 is key2 (backward).
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (key_s_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = key_s_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    case (press_q)
      2'b01:   sel_d = sel_q + 2'd1;
      2'b10:   sel_d = sel_q - 2'd1;
      default: sel_d = sel_q;
    endcase
  end

  always_comb begin
    led_d = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      led_d[i] = ~(din_s_q & (sel_q == 2'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1_q    <= 1'b0;
      din_s_q     <= 1'b0;
      key_s1_q    <= 2'b11;
      key_s_q     <= 2'b11;
      stable_q    <= 2'b11;
      stable_d1_q <= 2'b11;
      press_q     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      sel_q       <= SEL_RST;
      led_q       <= 4'b1111;
    end else begin
      din_s1_q    <= din;
      din_s_q     <= din_s1_q;
      key_s1_q    <= {key2, key1};
      key_s_q     <= key_s1_q;
      stable_q    <= stable_d;
      stable_d1_q <= stable_q;
      // Press is a falling edge of the debounced level; releases are ignored.
      press_q     <= stable_d1_q & ~stable_q;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sel_q       <= sel_d;
      led_q       <= led_d;
    end
  end

  assign led = led_q;
  assign sel = sel_q;

endmodule
